pulse_delay_generator: RTL

Multi-channel programmable delay-and-pulse generator: each channel waits a programmable number of clock cycles after its trigger, then drives a pulse of programmable width. It supersedes the single-channel, fixed-one-cycle-pulse delay block. Channels are fully independent and have a selectable retrigger policy. It sits between the pulse-sequencer trigger lines and the timing outputs (DDS/AOM gates, counter gates).

---
 rtl/pulse_delay_generator_pkg.sv | 20 ++
 rtl/pulse_delay_generator_if.sv | 28 ++
 rtl/pulse_delay_channel.sv | 99 +++++++++
 rtl/pulse_delay_generator.sv | 33 +++
 4 files changed

// File: rtl/pulse_delay_generator_pkg.sv
// Shared state encodings, retrigger policies and the per-channel output bundle.
// Pure declarations; no latency, no backpressure.
package delay_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } ch_state_e;

    localparam logic RETRIG_IGNORE  = 1'b0;
    localparam logic RETRIG_RESTART = 1'b1;

    typedef struct packed {
        logic q;
        logic busy;
        logic missed;
    } ch_out_t;

endpackage

// File: rtl/pulse_delay_generator_if.sv
// Trigger/config inputs and pulse/status outputs of the multi-channel delay generator.
// Plain wires; no latency, no backpressure (level-sampled every cycle).
interface pulse_delay_generator_if #(
    parameter int NumChannels = 4,
    parameter int DelayWidth  = 16,
    parameter int PulseWidth  = 8
);

    logic [NumChannels-1:0]            enable;
    logic [NumChannels-1:0]            trigger;
    logic [NumChannels*DelayWidth-1:0] delay;
    logic [NumChannels*PulseWidth-1:0] width;
    logic [NumChannels-1:0]            retrigger;
    logic [NumChannels-1:0]            q;
    logic [NumChannels-1:0]            busy;
    logic [NumChannels-1:0]            missed;

    modport master (
        output enable, trigger, delay, width, retrigger,
        input  q, busy, missed
    );

    modport slave (
        input  enable, trigger, delay, width, retrigger,
        output q, busy, missed
    );

endinterface

// File: rtl/pulse_delay_channel.sv
// One delay-then-pulse channel; q rises max(delay,1) edges after the accepting edge, lasts max(width,1).
// Registered outputs; no backpressure, triggers while busy are dropped (missed) or restart the channel.
module pulse_delay_channel
    import delay_gen_pkg::*;
#(
    parameter int DelayWidth = 16,
    parameter int PulseWidth = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  trigger,
    input  logic                  retrigger,
    input  logic [DelayWidth-1:0] delay,
    input  logic [PulseWidth-1:0] width,
    output logic                  q,
    output logic                  busy,
    output logic                  missed
);

    ch_state_e             state_r, state_nxt;
    logic [DelayWidth-1:0] dcnt_r, dcnt_nxt;
    logic [PulseWidth-1:0] wcnt_r, wcnt_nxt;
    ch_out_t               out_r, out_nxt;

    logic [DelayWidth-1:0] delay_eff;
    logic [PulseWidth-1:0] width_eff;
    logic                  active;
    logic                  last_edge;
    logic                  start;
    logic                  drop;

    assign delay_eff = (delay == '0) ? DelayWidth'(1) : delay;
    assign width_eff = (width == '0) ? PulseWidth'(1) : width;
    assign active    = (state_r != IDLE);

    // The edge that ends the pulse counts as idle so a held trigger runs back-to-back.
    assign last_edge = (state_r == PULSE) && (wcnt_r == PulseWidth'(1));
    assign start     = enable && trigger &&
                       (!active || last_edge || (retrigger == RETRIG_RESTART));
    assign drop      = enable && trigger && active && !last_edge &&
                       (retrigger == RETRIG_IGNORE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            dcnt_r  <= '0;
            wcnt_r  <= '0;
            out_r   <= '0;
        end else begin
            state_r <= state_nxt;
            dcnt_r  <= dcnt_nxt;
            wcnt_r  <= wcnt_nxt;
            out_r   <= out_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        if (!enable) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = DELAY;
        end else begin
            case (state_r)
                IDLE:    state_nxt = IDLE;
                DELAY:   if (dcnt_r == DelayWidth'(1)) state_nxt = PULSE;
                PULSE:   if (wcnt_r == PulseWidth'(1)) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counters are only ever loaded nonzero and decremented while their phase is live.
    always_comb begin
        dcnt_nxt = dcnt_r;
        wcnt_nxt = wcnt_r;
        if (!enable) begin
            dcnt_nxt = '0;
            wcnt_nxt = '0;
        end else if (start) begin
            dcnt_nxt = delay_eff;
            wcnt_nxt = width_eff;
        end else if (state_r == DELAY) begin
            dcnt_nxt = dcnt_r - DelayWidth'(1);
        end else if (state_r == PULSE) begin
            wcnt_nxt = wcnt_r - PulseWidth'(1);
        end

        out_nxt.q      = (state_nxt == PULSE);
        out_nxt.busy   = (state_nxt != IDLE);
        out_nxt.missed = drop;
    end

    assign q      = out_r.q;
    assign busy   = out_r.busy;
    assign missed = out_r.missed;

endmodule

// File: rtl/pulse_delay_generator.sv
// NumChannels independent delay-and-pulse channels sliced from flat config buses.
// Latency per channel is max(delay,1) to q rise; registered outputs, no backpressure.
module pulse_delay_generator
    import delay_gen_pkg::*;
#(
    parameter int NumChannels = 4,
    parameter int DelayWidth  = 16,
    parameter int PulseWidth  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pulse_delay_generator_if.slave  bus
);

    for (genvar i = 0; i < NumChannels; i++) begin : g_ch
        pulse_delay_channel #(
            .DelayWidth (DelayWidth),
            .PulseWidth (PulseWidth)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .enable    (bus.enable[i]),
            .trigger   (bus.trigger[i]),
            .retrigger (bus.retrigger[i]),
            .delay     (bus.delay[i*DelayWidth +: DelayWidth]),
            .width     (bus.width[i*PulseWidth +: PulseWidth]),
            .q         (bus.q[i]),
            .busy      (bus.busy[i]),
            .missed    (bus.missed[i])
        );
    end

endmodule
